// File: rtl/fc3_ctrl_pkg.sv
// Shared types and default widths for the fc3 double-buffer sequencer.
package fc3_ctrl_pkg;

  // Default widths, shared with the fc3 top level.
  localparam int FC3_LEN_WID = 12;
  localparam int FC3_WIN_WID = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    ACC  = 3'd2,
    WAIT = 3'd3
  } fc3_ctrl_state_t;

endpackage

// File: rtl/fc3_buffer_double_ctrl_if.sv
// Input-stream / output-bank handshakes plus accumulator bank controls.
// The sequencer is the master; the accumulator datapath and its neighbours form the slave side.
interface fc3_buffer_double_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic acc_sel;
  logic acc_clear;
  logic acc_hold;

  modport master (
    input  in_valid, out_ready,
    output in_ready, out_valid, acc_sel, acc_clear, acc_hold
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, out_valid, acc_sel, acc_clear, acc_hold
  );
endinterface

// File: rtl/fc3_ctrl_cnt.sv
// Up-counter with synchronous clear and a compare against a terminal value.
module fc3_ctrl_cnt #(
  parameter int WID = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_i,
  input  logic           inc_i,
  input  logic [WID-1:0] term_i,
  output logic [WID-1:0] cnt_o,
  output logic           at_term_o
);

  logic [WID-1:0] cnt_q;

  // Clear wins over increment so a window can end and restart on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (inc_i) cnt_q <= cnt_q + WID'(1);
  end

  assign cnt_o     = cnt_q;
  assign at_term_o = (cnt_q == term_i);

endmodule

// File: rtl/fc3_buffer_double_ctrl.sv
// Sequencer for the fc3 double-buffered accumulator: one bank accumulates a
// window of cfg_len beats while the other presents the previous window.
module fc3_buffer_double_ctrl
  import fc3_ctrl_pkg::*;
#(
  parameter int LEN_WID = FC3_LEN_WID,
  parameter int WIN_WID = FC3_WIN_WID
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WID-1:0]    cfg_len,
  input  logic [WIN_WID-1:0]    cfg_win,
  fc3_buffer_double_ctrl_if.master bus,
  output logic                  busy,
  output logic                  done
);

  fc3_ctrl_state_t    state_q;
  logic [LEN_WID-1:0] len_q;
  logic [WIN_WID-1:0] win_q;
  logic               acc_sel_q;
  logic               out_valid_q;
  logic               done_q;
  logic               last_pend_q;   // pending output window is the job's last

  logic [LEN_WID-1:0] beat_cnt;
  logic [WIN_WID-1:0] win_cnt;
  logic               beat_last;
  logic               win_last;

  logic start_ok;
  logic beat_acc;
  logic win_end;
  logic slot_free;
  logic swap;
  logic handshake;

  assign start_ok  = (state_q == IDLE) && start && (cfg_len != '0) && (cfg_win != '0);
  assign beat_acc  = (state_q == ACC) && bus.in_valid;
  assign win_end   = beat_acc && beat_last;
  // The presented bank may be reused only once the consumer has it (or takes it now).
  assign slot_free = !out_valid_q || bus.out_ready;
  assign swap      = (win_end || (state_q == WAIT)) && slot_free;
  assign handshake = out_valid_q && bus.out_ready;

  fc3_ctrl_cnt #(.WID(LEN_WID)) u_beat_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     ((state_q == CLR) || win_end),
    .inc_i     (beat_acc),
    .term_i    (len_q - LEN_WID'(1)),
    .cnt_o     (beat_cnt),
    .at_term_o (beat_last)
  );

  fc3_ctrl_cnt #(.WID(WIN_WID)) u_win_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (start_ok),
    .inc_i     (swap),
    .term_i    (win_q - WIN_WID'(1)),
    .cnt_o     (win_cnt),
    .at_term_o (win_last)
  );

  // Job FSM plus bank-select, output-valid and done bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      win_q       <= '0;
      acc_sel_q   <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      last_pend_q <= 1'b0;
    end else begin
      done_q <= handshake && last_pend_q;

      // A swap in the handshake cycle keeps out_valid high for the new bank.
      if (swap) begin
        acc_sel_q   <= !acc_sel_q;
        out_valid_q <= 1'b1;
        last_pend_q <= win_last;
      end else if (handshake) begin
        out_valid_q <= 1'b0;
        last_pend_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start_ok) begin
            len_q   <= cfg_len;
            win_q   <= cfg_win;
            state_q <= CLR;
          end
        end
        CLR:  state_q <= ACC;
        ACC: begin
          if (win_end) begin
            if (slot_free) state_q <= win_last ? IDLE : CLR;
            else           state_q <= WAIT;
          end
        end
        WAIT: begin
          if (slot_free) state_q <= win_last ? IDLE : CLR;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Accumulator hold follows in_valid only while accumulating.
  always_comb begin
    bus.acc_hold = 1'b1;
    case (state_q)
      CLR:     bus.acc_hold = 1'b0;
      ACC:     bus.acc_hold = !bus.in_valid;
      default: bus.acc_hold = 1'b1;
    endcase
  end

  assign bus.in_ready  = (state_q == ACC);
  assign bus.acc_clear = (state_q == CLR);
  assign bus.acc_sel   = acc_sel_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = (state_q != IDLE) || out_valid_q;
  assign done          = done_q;

endmodule

// File: tb/tb_fc3_buffer_double_ctrl.sv
// Randomised scoreboard bench for the fc3 double-buffer sequencer.
module tb_fc3_buffer_double_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] cfg_len;
  logic [7:0]  cfg_win;
  logic        busy;
  logic        done;
  logic [15:0] in_data;

  fc3_buffer_double_ctrl_if bus();

  fc3_buffer_double_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .cfg_len (cfg_len),
    .cfg_win (cfg_win),
    .bus     (bus),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Accumulator datapath model driven by the DUT's bank controls.
  logic [31:0] bank [2];
  always @(posedge clk) begin
    if (bus.acc_clear)      bank[bus.acc_sel] <= 32'd0;
    else if (!bus.acc_hold) bank[bus.acc_sel] <= bank[bus.acc_sel] + 32'(in_data);
  end

  typedef struct { logic [31:0] sum; bit last; } exp_t;
  exp_t        exp_q[$];
  logic [15:0] beat_q[$];

  // out_ready generator: 0 always ready, 1 random, 2 low until cycle ready_at.
  int cyc = 0;
  int rmode = 0;
  int ready_at = 0;
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = (cyc >= ready_at);
      endcase
    end
  end

  // Monitor: protocol rules from the window count, and window sums on each handshake.
  int  m_len = 0, m_beats = 0, done_cnt = 0;
  bit  wfull = 0, p_valid = 0, p_swap = 0, p_hold = 0, p_hs = 0, p_done = 0, rst_chk = 0;
  logic p_sel = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      if (!rst_chk) begin
        chk("rst_acc_sel",   bus.acc_sel,   0);
        chk("rst_acc_hold",  bus.acc_hold,  1);
        chk("rst_acc_clear", bus.acc_clear, 0);
        chk("rst_in_ready",  bus.in_ready,  0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy",      busy,          0);
        chk("rst_done",      done,          0);
        rst_chk = 1;
      end
      exp_q.delete();
      wfull = 0; p_valid = 0; p_done = 0; m_beats = 0;
    end else begin
      bit acc_now, slot, wdone;
      rst_chk = 0;
      if (p_valid) begin
        chk("acc_sel_seq", bus.acc_sel, p_sel ^ p_swap);
        if (p_swap)      chk("ov_after_swap", bus.out_valid, 1);
        else if (p_hold) chk("ov_held",       bus.out_valid, 1);
        else if (p_hs)   chk("ov_drop",       bus.out_valid, 0);
      end
      if (done || p_done) chk("done_timing", done, p_done);
      if (done) done_cnt++;
      if (bus.in_ready) chk("hold_vs_valid", bus.acc_hold, !bus.in_valid);
      if (bus.acc_clear) begin
        chk("clr_in_ready", bus.in_ready, 0);
        chk("clr_hold",     bus.acc_hold, 0);
      end
      if (wfull) begin
        chk("wait_in_ready", bus.in_ready, 0);
        chk("wait_hold",     bus.acc_hold, 1);
      end
      p_hs = bus.out_valid && bus.out_ready;
      p_done = 0;
      if (p_hs) begin
        if (exp_q.size() == 0) chk("exp_underflow", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("window_sum", bank[bus.acc_sel ? 0 : 1], e.sum);
          p_done = e.last;
        end
      end
      if (start && cfg_len != 0 && cfg_win != 0 && !busy) begin
        m_len = int'(cfg_len); m_beats = 0; wfull = 0;
      end
      acc_now = bus.in_valid && bus.in_ready;
      slot    = !bus.out_valid || bus.out_ready;
      wdone   = acc_now && (m_beats + 1 == m_len);
      if (acc_now) m_beats = wdone ? 0 : m_beats + 1;
      p_swap  = (wdone || wfull) && slot;
      wfull   = (wdone || wfull) && !slot;
      p_sel   = bus.acc_sel;
      p_hold  = bus.out_valid && !bus.out_ready;
      p_valid = 1;
    end
  end

  // One job: vmode 0 valid high, 1 toggling, 2 random; abort_at>0 resets after that many beats.
  task automatic run_job(input int len, input int win, input int vmode, input int rm,
                         input int ready_low, input int abort_at);
    int n_acc = 0, guard = 0, d0;
    bit tog = 1, acc;
    d0 = done_cnt;
    rmode = rm; ready_at = cyc + ready_low;
    for (int w = 0; w < win; w++) begin
      exp_t e;
      e.sum = 0;
      for (int b = 0; b < len; b++) begin
        logic [15:0] d;
        d = 16'($urandom_range(0, 65535));
        beat_q.push_back(d);
        e.sum += 32'(d);
      end
      e.last = (w == win - 1);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1; cfg_len = 12'(len); cfg_win = 8'(win);
    @(posedge clk); #1;
    start = 0;
    while (beat_q.size() > 0 && guard < 5000) begin
      in_data = beat_q[0];
      bus.in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = !tog;
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        void'(beat_q.pop_front());
        n_acc++;
        if (abort_at != 0 && n_acc == abort_at) begin
          rst_n = 0; bus.in_valid = 0;
          #1;
          chk("abort_acc_sel",   bus.acc_sel,   0);
          chk("abort_out_valid", bus.out_valid, 0);
          chk("abort_in_ready",  bus.in_ready,  0);
          chk("abort_busy",      busy,          0);
          beat_q.delete();
          @(negedge clk);
          @(posedge clk); #1;
          rst_n = 1;
          #1;
          chk("abort_no_done", done_cnt, d0);
          return;
        end
      end
    end
    chk("feed_timeout", guard < 5000, 1);
    bus.in_valid = 0;
    guard = 0;
    while ((exp_q.size() > 0 || busy) && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_timeout", guard < 2000, 1);
    @(negedge clk); @(negedge clk);
    chk("done_count", done_cnt - d0, 1);
    $display("[TB] job len=%0d win=%0d vmode=%0d rmode=%0d done", len, win, vmode, rm);
  endtask

  // A start with a zero configuration field must be ignored.
  task automatic zero_cfg(input int len, input int win);
    int d0;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1; cfg_len = 12'(len); cfg_win = 8'(win);
    @(posedge clk); #1;
    start = 0;
    repeat (4) begin
      @(negedge clk);
      chk("zero_busy",     busy,          0);
      chk("zero_in_ready", bus.in_ready,  0);
      chk("zero_clear",    bus.acc_clear, 0);
    end
    chk("zero_no_done", done_cnt, d0);
    $display("[TB] zero cfg len=%0d win=%0d ignored", len, win);
  endtask

  initial begin
    rst_n = 0; start = 0; cfg_len = 0; cfg_win = 0;
    bus.in_valid = 0; in_data = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    run_job(4, 2, 0, 0, 0, 0);
    run_job(3, 3, 0, 2, 20, 0);
    run_job(5, 2, 1, 0, 0, 0);
    run_job(5, 3, 1, 1, 0, 0);
    zero_cfg(0, 2);
    zero_cfg(3, 0);
    run_job(4, 1, 0, 0, 0, 2);
    @(negedge clk);
    chk("post_rst_acc_sel", bus.acc_sel, 0);
    run_job(4, 1, 0, 0, 0, 0);
    run_job(1, 4, 0, 1, 0, 0);
    for (int j = 0; j < 8; j++)
      run_job($urandom_range(1, 6), $urandom_range(1, 4), 2, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
